// File: rtl/lemmings_world_pkg.sv
// Shared types for the lemmings track world: walker-world state encoding and depth width.
package lemmings_world_pkg;

  typedef enum logic [1:0] {
    WALK = 2'd0,
    FALL = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int DEPTH_W = 5;

endpackage

// File: rtl/lemmings_world.sv
// 1-D track environment for a lemming walker: walls, holes that fill after a fall, protocol watch.
// Optional splat-on-long-fall behaviour is enabled by defining LEMMINGS_WORLD_SPLAT_EN.
module lemmings_world
  import lemmings_world_pkg::*;
#(
  parameter int N_CELLS     = 16,
  parameter int START_POS   = 2,
  parameter int SPLAT_LIMIT = 20
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       walk_left,
  input  logic                       walk_right,
  input  logic                       aaah,
  input  logic [N_CELLS-1:0]         hole_map,
  input  logic [DEPTH_W-1:0]         depth,
  output logic                       turn_left,
  output logic                       turn_right,
  output logic                       ground,
  output logic [$clog2(N_CELLS)-1:0] pos,
  output logic                       splat,
  output logic                       proto_err
);

  localparam int POS_W = $clog2(N_CELLS);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_CELLS - 1);
  localparam logic [POS_W-1:0] INIT_POS = POS_W'(START_POS);

  // With the macro undefined DEAD is unreachable and splat_reg is constant 0.
`ifdef LEMMINGS_WORLD_SPLAT_EN
  localparam bit SPLAT_EN = 1'b1;
`else
  localparam bit SPLAT_EN = 1'b0;
`endif

  state_t               state_reg,      state_next;
  logic [POS_W-1:0]     pos_reg,        pos_next;
  logic                 ground_reg,     ground_next;
  logic                 turn_left_reg,  turn_left_next;
  logic                 turn_right_reg, turn_right_next;
  logic                 splat_reg,      splat_next;
  logic                 proto_err_reg,  proto_err_next;
  logic [DEPTH_W-1:0]   fall_cnt_reg,   fall_cnt_next;
  logic [DEPTH_W-1:0]   fall_len_reg,   fall_len_next;
  logic [N_CELLS-1:0]   filled_reg,     filled_next;
  logic                 aaah_low_reg,   aaah_low_next;

  logic                 bad_combo;
  logic                 moved;
  logic [DEPTH_W-1:0]   fall_cnt_inc;
  logic                 splat_hit;

  assign bad_combo    = (walk_left & walk_right) | (aaah & (walk_left | walk_right));
  assign fall_cnt_inc = fall_cnt_reg + DEPTH_W'(1);
  assign splat_hit    = SPLAT_EN && (int'(fall_len_reg) >= SPLAT_LIMIT);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg      <= WALK;
      pos_reg        <= INIT_POS;
      ground_reg     <= 1'b1;
      turn_left_reg  <= 1'b0;
      turn_right_reg <= 1'b0;
      splat_reg      <= 1'b0;
      proto_err_reg  <= 1'b0;
      fall_cnt_reg   <= '0;
      fall_len_reg   <= '0;
      filled_reg     <= '0;
      aaah_low_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pos_reg        <= pos_next;
      ground_reg     <= ground_next;
      turn_left_reg  <= turn_left_next;
      turn_right_reg <= turn_right_next;
      splat_reg      <= splat_next;
      proto_err_reg  <= proto_err_next;
      fall_cnt_reg   <= fall_cnt_next;
      fall_len_reg   <= fall_len_next;
      filled_reg     <= filled_next;
      aaah_low_reg   <= aaah_low_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pos_next        = pos_reg;
    ground_next     = ground_reg;
    turn_left_next  = 1'b0;
    turn_right_next = 1'b0;
    splat_next      = splat_reg;
    proto_err_next  = proto_err_reg | bad_combo;
    fall_cnt_next   = fall_cnt_reg;
    fall_len_next   = fall_len_reg;
    filled_next     = filled_reg;
    aaah_low_next   = 1'b0;
    moved           = 1'b0;

    case (state_reg)
      WALK: begin
        ground_next = 1'b1;
        if (!bad_combo) begin
          if (walk_right) begin
            if (pos_reg == LAST_POS) begin
              turn_left_next = 1'b1;
            end else begin
              pos_next = pos_reg + POS_W'(1);
              moved    = 1'b1;
            end
          end else if (walk_left) begin
            if (pos_reg == '0) begin
              turn_right_next = 1'b1;
            end else begin
              pos_next = pos_reg - POS_W'(1);
              moved    = 1'b1;
            end
          end
        end
        // Stepping onto an unfilled hole starts the fall on the very next cycle.
        if (moved && hole_map[pos_next] && !filled_reg[pos_next]) begin
          ground_next   = 1'b0;
          state_next    = FALL;
          fall_cnt_next = '0;
          fall_len_next = (depth == '0) ? DEPTH_W'(1) : depth;
        end
      end

      FALL: begin
        ground_next   = 1'b0;
        aaah_low_next = ~aaah;
        if (!aaah && aaah_low_reg) begin
          proto_err_next = 1'b1;
        end
        if (fall_cnt_inc == fall_len_reg) begin
          fall_cnt_next        = '0;
          ground_next          = 1'b1;
          filled_next[pos_reg] = 1'b1;
          if (splat_hit) begin
            state_next = DEAD;
            splat_next = 1'b1;
          end else begin
            state_next = WALK;
          end
        end else begin
          fall_cnt_next = fall_cnt_inc;
        end
      end

      DEAD: begin
        ground_next = 1'b1;
        splat_next  = 1'b1;
      end

      default: begin
        state_next  = WALK;
        ground_next = 1'b1;
      end
    endcase
  end

  assign turn_left  = turn_left_reg;
  assign turn_right = turn_right_reg;
  assign ground     = ground_reg;
  assign pos        = pos_reg;
  assign splat      = splat_reg;
  assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_lemmings_world.sv
// Directed bench for lemmings_world: walls, holes, fall timing, protocol errors, async reset.
module tb_lemmings_world;

  logic        clk = 1'b0;
  logic        areset;
  logic        walk_left, walk_right, aaah;
  logic [15:0] hole_map;
  logic [4:0]  depth;
  logic        turn_left, turn_right, ground, splat, proto_err;
  logic [3:0]  pos;

  int vec_cnt = 0;
  int err_cnt = 0;

  lemmings_world #(.N_CELLS(16), .START_POS(2), .SPLAT_LIMIT(20)) dut (
    .clk        (clk),
    .areset     (areset),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .hole_map   (hole_map),
    .depth      (depth),
    .turn_left  (turn_left),
    .turn_right (turn_right),
    .ground     (ground),
    .pos        (pos),
    .splat      (splat),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("vec %0d %s = %0d ok", vec_cnt, tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] holes, input logic [4:0] d);
    walk_left  = 1'b0;
    walk_right = 1'b0;
    aaah       = 1'b0;
    hole_map   = holes;
    depth      = d;
    areset     = 1'b1;
    step();
    areset     = 1'b0;
  endtask

  task automatic walk_to_five();
    walk_right = 1'b1;
    step(); check_eq("approach_pos3", 32'(pos), 3);
    step(); check_eq("approach_pos4", 32'(pos), 4);
    step(); check_eq("enter_pos5", 32'(pos), 5);
    check_eq("enter_ground", 32'(ground), 0);
  endtask

  initial begin
    // Reset state
    walk_left = 0; walk_right = 0; aaah = 0; hole_map = '0; depth = '0;
    areset = 1'b1;
    step();
    check_eq("rst_pos", 32'(pos), 2);
    check_eq("rst_ground", 32'(ground), 1);
    check_eq("rst_turns", 32'({turn_left, turn_right}), 0);
    check_eq("rst_splat", 32'(splat), 0);
    check_eq("rst_proto", 32'(proto_err), 0);
    areset = 1'b0;

    // Walk right to the far wall
    walk_right = 1'b1;
    for (int p = 3; p <= 15; p++) begin
      step();
      check_eq("right_pos", 32'(pos), 32'(p));
    end
    step();
    check_eq("wall_r_pos", 32'(pos), 15);
    check_eq("wall_r_turn_left", 32'(turn_left), 1);
    check_eq("wall_r_turn_right", 32'(turn_right), 0);
    walk_right = 1'b0; walk_left = 1'b1;
    step();
    check_eq("wall_r_pulse_end", 32'(turn_left), 0);
    check_eq("wall_r_back_pos", 32'(pos), 14);

    // Walk left to cell 0
    do_reset(16'h0000, 5'd0);
    walk_left = 1'b1;
    step(); check_eq("left_pos1", 32'(pos), 1);
    step(); check_eq("left_pos0", 32'(pos), 0);
    step();
    check_eq("wall_l_pos", 32'(pos), 0);
    check_eq("wall_l_turn_right", 32'(turn_right), 1);
    walk_left = 1'b0; walk_right = 1'b1;
    step();
    check_eq("wall_l_pulse_end", 32'(turn_right), 0);
    check_eq("wall_l_back_pos", 32'(pos), 1);

    // Depth-4 hole at cell 5, then revisit after it is filled
    do_reset(16'h0020, 5'd4);
    walk_to_five();
    walk_right = 1'b0; aaah = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("fall4_ground", 32'(ground), 0);
      check_eq("fall4_pos", 32'(pos), 5);
    end
    step();
    check_eq("land4_ground", 32'(ground), 1);
    aaah = 1'b0; walk_left = 1'b1;
    step(); check_eq("back_pos4", 32'(pos), 4);
    step(); check_eq("back_pos3", 32'(pos), 3);
    walk_left = 1'b0; walk_right = 1'b1;
    step(); check_eq("again_pos4", 32'(pos), 4);
    step();
    check_eq("filled_pos5", 32'(pos), 5);
    check_eq("filled_ground", 32'(ground), 1);
    step();
    check_eq("past_pos6", 32'(pos), 6);
    check_eq("fall4_proto", 32'(proto_err), 0);

    // Depth 0 at edge cell 0 acts as a one-cycle fall
    do_reset(16'h0001, 5'd0);
    walk_left = 1'b1;
    step(); check_eq("edge_pos1", 32'(pos), 1);
    step();
    check_eq("edge_pos0", 32'(pos), 0);
    check_eq("edge_ground0", 32'(ground), 0);
    walk_left = 1'b0; aaah = 1'b1;
    step(); check_eq("edge_land", 32'(ground), 1);
    aaah = 1'b0; walk_left = 1'b1;
    step();
    check_eq("edge_turn_right", 32'(turn_right), 1);
    check_eq("edge_after_ground", 32'(ground), 1);

    // Depth-25 fall: splat when enabled, normal landing otherwise
    do_reset(16'h0020, 5'd25);
    walk_to_five();
    walk_right = 1'b0; aaah = 1'b1;
    for (int i = 0; i < 24; i++) step();
    check_eq("long_fall_ground", 32'(ground), 0);
    step();
    check_eq("long_land_ground", 32'(ground), 1);
    aaah = 1'b0; walk_right = 1'b1;
    step();
`ifdef LEMMINGS_WORLD_SPLAT_EN
    check_eq("splat_flag", 32'(splat), 1);
    check_eq("splat_pos", 32'(pos), 5);
    check_eq("splat_ground", 32'(ground), 1);
`else
    check_eq("splat_flag", 32'(splat), 0);
    check_eq("long_walk_pos", 32'(pos), 6);
`endif
    check_eq("long_turn_left", 32'(turn_left), 0);

    // Missing aaah for two fall cycles
    do_reset(16'h0020, 5'd8);
    walk_to_five();
    walk_right = 1'b0;
    step(); check_eq("noaaah_1", 32'(proto_err), 0);
    step(); check_eq("noaaah_2", 32'(proto_err), 1);

    // Both walk inputs at once
    do_reset(16'h0000, 5'd0);
    walk_left = 1'b1; walk_right = 1'b1;
    step();
    check_eq("both_proto", 32'(proto_err), 1);
    check_eq("both_pos", 32'(pos), 2);
    walk_left = 1'b0;
    step();
    check_eq("both_sticky", 32'(proto_err), 1);
    check_eq("both_then_pos", 32'(pos), 3);

    // aaah together with a walk input
    do_reset(16'h0000, 5'd0);
    aaah = 1'b1; walk_right = 1'b1;
    step();
    check_eq("aaah_walk_proto", 32'(proto_err), 1);
    check_eq("aaah_walk_pos", 32'(pos), 2);

    // Asynchronous reset during the second cycle of a depth-8 fall
    do_reset(16'h0008, 5'd8);
    walk_right = 1'b1;
    step();
    check_eq("abort_enter_pos", 32'(pos), 3);
    check_eq("abort_enter_ground", 32'(ground), 0);
    walk_right = 1'b0; aaah = 1'b1;
    step();
    #3 areset = 1'b1;
    #1;
    check_eq("abort_pos", 32'(pos), 2);
    check_eq("abort_ground", 32'(ground), 1);
    step();
    areset = 1'b0; aaah = 1'b0; walk_right = 1'b1;
    step();
    check_eq("abort_reenter_pos", 32'(pos), 3);
    check_eq("abort_unfilled", 32'(ground), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lemmings_world.md
LEMMINGS_WORLD -- requirements
Module: lemmings_world

Interface
REQ-001 Parameter N_CELLS, default 16: number of cells in the 1-D track, indexed 0..N_CELLS-1.
REQ-002 Parameter START_POS, default 2: walker cell after reset.
REQ-003 Parameter SPLAT_LIMIT, default 20: fall length (cycles) at or above which the walker dies.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 areset  input  1  asynchronous, active-high reset.
REQ-006 walk_left, walk_right, aaah  input  1 each  walker state outputs, sampled every cycle.
REQ-007 hole_map  input  N_CELLS  bit i = 1 marks cell i as a hole; held static by the bench.
REQ-008 depth  input  5  fall length in cycles for the hole being entered; sampled on fall entry.
REQ-009 turn_left, turn_right, ground  output  1 each  registered stimulus to the walker.
REQ-010 pos  output  $clog2(N_CELLS)  current walker cell.
REQ-011 splat  output  1  sticky death indication.
REQ-012 proto_err  output  1  sticky walker-protocol violation.

Function
REQ-013 The block SHALL be a three-state machine: WALK, FALL, DEAD.
REQ-014 In WALK with walk_right=1: pos<N_CELLS-1 -> pos+1; pos=N_CELLS-1 -> pos held, turn_left=1 for exactly one cycle.
REQ-015 In WALK with walk_left=1: pos>0 -> pos-1; pos=0 -> pos held, turn_right=1 for exactly one cycle.
REQ-016 turn_left and turn_right SHALL never both be 1 and SHALL be 0 outside WALK.
REQ-017 ground SHALL be registered: 1 in WALK unless the cell just entered is an unfilled hole; 0 throughout FALL.
REQ-018 Entering an unfilled hole cell: ground=0 from the next cycle, state -> FALL, fall length latched from depth (value 0 treated as 1).
REQ-019 A fall counter SHALL count FALL cycles; when it reaches the latched length, ground=1, that cell's filled bit set, state -> WALK, pos unchanged.
REQ-020 Filled holes SHALL behave as ground for the rest of the run.
REQ-021 walk_left/walk_right SHALL be ignored in FALL and DEAD; pos never changes there.
REQ-022 proto_err SHALL set on walk_left&walk_right, or on aaah together with either walk input; such a cycle causes no movement.
REQ-023 proto_err SHALL also set if aaah=0 for two consecutive cycles while in FALL and ground=0.
REQ-024 Simultaneous wall bump and hole is impossible by construction (walls are track ends, holes are cells); a hole at cell 0 or N_CELLS-1 SHALL be legal.

Reset
REQ-025 areset SHALL immediately force: state WALK, pos=START_POS, ground=1, turn_left=0, turn_right=0, splat=0, proto_err=0, fall counter 0, all filled bits 0.
REQ-026 areset asserted mid-fall SHALL abandon the fall without setting the filled bit.

Configuration
REQ-027 Macro LEMMINGS_WORLD_SPLAT_EN defined: latched fall length >= SPLAT_LIMIT -> on landing, state -> DEAD, splat=1, ground=1, turn outputs 0, until reset.
REQ-028 Macro undefined: DEAD state is absent, splat is tied 0, and every fall lands normally.

Structure
REQ-029 A shared package SHALL hold the state enum (WALK, FALL, DEAD) and the depth width constant.
REQ-030 No sub-module; the fall counter and filled-bit register live in the top module.

Verification
REQ-031 Reset release, hole_map=0, walk_right held -> pos 2,3,...,15, then turn_left pulses one cycle at pos=15.
REQ-032 walk_left held from pos=2, no holes -> pos 1,0, then turn_right pulses one cycle, pos stays 0.
REQ-033 hole_map bit 5 set, depth=4, walk_right then aaah for the fall -> ground=0 for 4 cycles at pos=5, then ground=1; a second pass over cell 5 keeps ground=1.
REQ-034 With LEMMINGS_WORLD_SPLAT_EN, depth=25 -> splat=1 after landing, pos frozen, ground=1; without the macro the same fall lands and splat stays 0.
REQ-035 walk_left=walk_right=1 for one cycle -> proto_err=1 and stays 1; pos unchanged.
REQ-036 areset pulsed during the 2nd cycle of a depth-8 fall -> pos=2, ground=1, and the hole cell is still unfilled afterwards.
